// File: rtl/accel_bus_pkg.sv
// Shared definitions for the AXI4-Lite to register-bus bridge: widths, response codes, FSM states.
package accel_bus_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned REG_ADDR_W = 16;
  localparam int unsigned RESP_W     = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } state_e;

endpackage

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave that converts single transactions into one-cycle register-bus strobes.
// One transaction in flight; simultaneous read/write requests alternate priority.
module axi_lite_reg_bridge
  import accel_bus_pkg::*;
#(
  parameter int unsigned ADDR_LSB = 3,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [AXI_ADDR_W-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [RESP_W-1:0]     bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [AXI_ADDR_W-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [RESP_W-1:0]     rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [REG_ADDR_W-1:0] read_addr,
  output logic                  oe,
  input  logic [DATA_W-1:0]     read_data,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0]     write_data,
  output logic [STRB_W-1:0]     be,
  output logic                  we
);

  state_e state, state_n;
  logic   last_was_read;
  logic   oor_q;
  logic   wr_pend, rd_pend, wr_grant, rd_grant;
  logic   aw_oor, ar_oor;
  logic [REG_ADDR_W-1:0] aw_idx, ar_idx;

  function automatic logic out_of_range(input logic [AXI_ADDR_W-1:0] a);
    logic [AXI_ADDR_W-1:0] upper;
    logic [REG_ADDR_W-1:0] idx;
    upper = a >> (ADDR_LSB + REG_ADDR_W);
    idx   = REG_ADDR_W'(a >> ADDR_LSB);
    return (upper != '0) || (32'(idx) >= NUM_REGS);
  endfunction

  assign aw_idx  = REG_ADDR_W'(awaddr >> ADDR_LSB);
  assign ar_idx  = REG_ADDR_W'(araddr >> ADDR_LSB);
  assign aw_oor  = out_of_range(awaddr);
  assign ar_oor  = out_of_range(araddr);
  assign wr_pend = awvalid && wvalid;
  assign rd_pend = arvalid;

  assign awready = wr_grant;
  assign wready  = wr_grant;
  assign arready = rd_grant;

  // Next-state and grant decode; grants only in IDLE and never while reset is held
  always_comb begin
    state_n  = state;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    case (state)
      IDLE: begin
        if (resetn) begin
          if (wr_pend && (!rd_pend || last_was_read)) begin
            wr_grant = 1'b1;
            state_n  = WR_ISSUE;
          end else if (rd_pend) begin
            rd_grant = 1'b1;
            state_n  = RD_ISSUE;
          end
        end
      end
      WR_ISSUE: state_n = WR_RESP;
      WR_RESP:  if (bready) state_n = IDLE;
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT:  state_n = RD_RESP;
      RD_RESP:  if (rready) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // State, request latches and registered bus/response outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      last_was_read <= 1'b0;
      oor_q         <= 1'b0;
      write_addr    <= '0;
      write_data    <= '0;
      be            <= '0;
      we            <= 1'b0;
      read_addr     <= '0;
      oe            <= 1'b0;
      bvalid        <= 1'b0;
      bresp         <= RESP_OKAY;
      rvalid        <= 1'b0;
      rresp         <= RESP_OKAY;
      rdata         <= '0;
    end else begin
      state  <= state_n;
      we     <= wr_grant && !aw_oor;
      oe     <= rd_grant && !ar_oor;
      bvalid <= (state_n == WR_RESP);
      rvalid <= (state_n == RD_RESP);
      if (wr_grant) begin
        last_was_read <= 1'b0;
        oor_q         <= aw_oor;
        write_addr    <= aw_idx;
        write_data    <= wdata;
        be            <= wstrb;
      end
      if (rd_grant) begin
        last_was_read <= 1'b1;
        oor_q         <= ar_oor;
        read_addr     <= ar_idx;
      end
      if (state == WR_ISSUE) bresp <= oor_q ? RESP_SLVERR : RESP_OKAY;
      // read_data is valid the cycle after oe, i.e. during RD_WAIT
      if (state == RD_WAIT) begin
        rdata <= oor_q ? '0 : read_data;
        rresp <= oor_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Scoreboard bench for axi_lite_reg_bridge: a driver pushes expected events, a monitor pops and compares.
module tb_axi_lite_reg_bridge;

  localparam int unsigned NREG = 16;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, oe, we;
  logic [63:0] wdata, rdata, read_data, write_data;
  logic [7:0]  wstrb, be;
  logic [1:0]  bresp, rresp;
  logic [15:0] read_addr, write_addr;

  axi_lite_reg_bridge #(.ADDR_LSB(3), .NUM_REGS(NREG)) dut (
    .clock(clock), .resetn(resetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .read_addr(read_addr), .oe(oe), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .be(be), .we(we)
  );

  always #5 clock = ~clock;

  typedef struct { logic [15:0] addr; logic [63:0] data; logic [7:0] be; } we_t;
  typedef struct { logic [63:0] data; logic [1:0] resp; } r_t;

  we_t         we_q[$];
  logic [15:0] oe_q[$];
  logic [1:0]  b_q[$];
  r_t          r_q[$];
  bit          g_q[$];   // 1 = read granted, 0 = write granted

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [63:0] model_mem[NREG];
  logic [63:0] slave_mem[NREG];
  bit model_last_read = 1'b0;
  bit force_rr_low = 1'b0;
  bit slave_primed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_val(input int i);
    return {32'hCAFE_0000 + 32'(i), 32'h0BAD_0000 + 32'(i * 7)};
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a / 8) < NREG;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Downstream register file: captures we, returns data the cycle after oe, junk otherwise
  always @(posedge clock) begin
    if (!slave_primed) begin
      for (int i = 0; i < NREG; i++) slave_mem[i] <= init_val(i);
      slave_primed <= 1'b1;
    end else if (we) begin
      slave_mem[write_addr[3:0]] <= merge(slave_mem[write_addr[3:0]], write_data, be);
    end
    if (oe) read_data <= slave_mem[read_addr[3:0]];
    else    read_data <= {$urandom, $urandom};
  end

  always @(posedge clock) cyc++;

  // Random response backpressure
  always @(posedge clock) begin
    #1;
    bready = ($urandom % 3) != 0;
    rready = force_rr_low ? 1'b0 : (($urandom % 3) != 0);
  end

  // Reference model: expected events derived from address arithmetic and a word array
  task automatic push_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    we_t e;
    g_q.push_back(1'b0);
    if (in_range(a)) begin
      e.addr = 16'(a / 8); e.data = d; e.be = s;
      we_q.push_back(e);
      model_mem[a / 8] = merge(model_mem[a / 8], d, s);
      b_q.push_back(2'b00);
    end else begin
      b_q.push_back(2'b10);
    end
    model_last_read = 1'b0;
  endtask

  task automatic push_read(input logic [31:0] a);
    r_t e;
    g_q.push_back(1'b1);
    if (in_range(a)) begin
      oe_q.push_back(16'(a / 8));
      e.data = model_mem[a / 8]; e.resp = 2'b00;
    end else begin
      e.data = 64'h0; e.resp = 2'b10;
    end
    r_q.push_back(e);
    model_last_read = 1'b1;
  endtask

  // Present a write, a read or both; returns at posedge+1 once every request is granted
  task automatic issue(input bit dw, input bit dr, input logic [31:0] wa, input logic [63:0] wd,
                       input logic [7:0] ws, input logic [31:0] ra);
    int n;
    bit wg, rg;
    if (dw && dr) begin
      if (model_last_read) begin push_write(wa, wd, ws); push_read(ra); end
      else begin push_read(ra); push_write(wa, wd, ws); end
    end else if (dw) push_write(wa, wd, ws);
    else if (dr) push_read(ra);
    awaddr = wa; wdata = wd; wstrb = ws; araddr = ra;
    awvalid = dw; wvalid = dw; arvalid = dr;
    n = 0;
    while ((awvalid || arvalid) && n < 100) begin
      @(negedge clock);
      n++;
      wg = awvalid && awready;
      rg = arvalid && arready;
      if (wg || rg) begin
        @(posedge clock); #1;
        if (wg) begin awvalid = 1'b0; wvalid = 1'b0; end
        if (rg) arvalid = 1'b0;
      end
    end
    if (awvalid || arvalid) begin
      check("grant_timeout", 64'(awvalid | arvalid), 64'h0);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((g_q.size() + we_q.size() + oe_q.size() + b_q.size() + r_q.size()) != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    check("drain_done", 64'(g_q.size() + we_q.size() + oe_q.size() + b_q.size() + r_q.size()), 64'h0);
    @(posedge clock); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({awready, wready, bvalid, arready, rvalid, oe, we, bresp, rresp}), 64'h0);
    check({tag, "_rdata"}, rdata, 64'h0);
    check({tag, "_wdata"}, write_data, 64'h0);
    check({tag, "_addr"}, 64'({read_addr, write_addr, be}), 64'h0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  int wacc = 0, racc = 0;
  bit prev_rv = 1'b0, prev_rr = 1'b0;
  logic [63:0] prev_rdata;
  logic [1:0]  prev_rresp;
  always @(negedge clock) begin
    we_t ew;
    r_t  er;
    if (!resetn) begin
      prev_rv = 1'b0;
    end else begin
      if (we || oe) check("we_oe_exclusive", 64'(we & oe), 64'h0);
      if (awready && awvalid && wvalid) begin
        if (g_q.size() == 0) check("unexpected_write_grant", 64'h1, 64'h0);
        else check("grant_order", 64'(g_q.pop_front()), 64'h0);
        wacc = cyc;
      end
      if (arready && arvalid) begin
        if (g_q.size() == 0) check("unexpected_read_grant", 64'h1, 64'h0);
        else check("grant_order", 64'(g_q.pop_front()), 64'h1);
        racc = cyc;
      end
      if (we) begin
        if (we_q.size() == 0) check("unexpected_we", 64'h1, 64'h0);
        else begin
          ew = we_q.pop_front();
          check("we_addr", 64'(write_addr), 64'(ew.addr));
          check("we_data", write_data, ew.data);
          check("we_be", 64'(be), 64'(ew.be));
          check("we_latency", 64'(cyc - wacc), 64'd1);
        end
      end
      if (oe) begin
        if (oe_q.size() == 0) check("unexpected_oe", 64'h1, 64'h0);
        else check("oe_addr", 64'(read_addr), 64'(oe_q.pop_front()));
      end
      if (rvalid && !prev_rv) check("rvalid_latency", 64'(cyc - racc), 64'd3);
      if (prev_rv && !prev_rr) begin
        check("r_hold_valid", 64'(rvalid), 64'h1);
        check("r_hold_data", rdata, prev_rdata);
        check("r_hold_resp", 64'(rresp), 64'(prev_rresp));
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) check("unexpected_bresp", 64'h1, 64'h0);
        else check("bresp", 64'(bresp), 64'(b_q.pop_front()));
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) check("unexpected_rresp", 64'h1, 64'h0);
        else begin
          er = r_q.pop_front();
          check("rdata", rdata, er.data);
          check("rresp", 64'(rresp), 64'(er.resp));
        end
      end
      prev_rv = rvalid; prev_rr = rready;
      prev_rdata = rdata; prev_rresp = rresp;
    end
  end

  logic [31:0] ra, wa;
  int n;

  initial begin
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    for (int i = 0; i < NREG; i++) model_mem[i] = init_val(i);

    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(posedge clock); #1;

    // A lone read sets last_was_read, so contended pairs then go write, read, write, read
    issue(1'b0, 1'b1, 32'h0, 64'h0, 8'h00, 32'h0000_0010);
    issue(1'b1, 1'b1, 32'h0000_0018, 64'hDEAD_BEEF_0123_4567, 8'hFF, 32'h0000_0020);
    issue(1'b1, 1'b1, 32'h0000_0080, 64'h1234_5678_9ABC_DEF0, 8'hFF, 32'h0000_0018);
    drain();

    issue(1'b0, 1'b1, 32'h0, 64'h0, 8'h00, 32'h0008_0000);
    issue(1'b0, 1'b1, 32'h0, 64'h0, 8'h00, 32'h0000_0078);
    issue(1'b1, 1'b0, 32'h0000_0028, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 32'h0);
    issue(1'b1, 1'b0, 32'h0000_0030, 64'hA5A5_5A5A_C3C3_3C3C, 8'h0F, 32'h0);
    issue(1'b0, 1'b1, 32'h0, 64'h0, 8'h00, 32'h0000_0030);
    drain();

    // Read response backpressure
    force_rr_low = 1'b1;
    issue(1'b0, 1'b1, 32'h0, 64'h0, 8'h00, 32'h0000_0018);
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clock); n++; end
    check("bp_rvalid_seen", 64'(rvalid), 64'h1);
    repeat (5) @(negedge clock);
    force_rr_low = 1'b0;
    @(posedge clock); #1;
    drain();

    // AW without W is never accepted
    awaddr = 32'h0000_0018; awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("aw_only_ready", 64'({awready, wready}), 64'h0);
    end
    @(posedge clock); #1;
    awvalid = 1'b0;
    issue(1'b1, 1'b0, 32'h0000_0018, 64'h0F0F_0F0F_F0F0_F0F0, 8'hF0, 32'h0);
    drain();

    // Reset during RD_WAIT abandons the read
    issue(1'b0, 1'b1, 32'h0, 64'h0, 8'h00, 32'h0000_0018);
    @(posedge clock); #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    g_q.delete(); we_q.delete(); oe_q.delete(); b_q.delete(); r_q.delete();
    model_last_read = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("no_resp_after_reset", 64'({rvalid, bvalid, oe, we}), 64'h0);
    end
    @(posedge clock); #1;
    issue(1'b0, 1'b1, 32'h0, 64'h0, 8'h00, 32'h0000_0018);
    drain();

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      int op, k;
      for (int j = 0; j < 2; j++) begin
        k = $urandom % 8;
        if (k < 6) ra = (($urandom % NREG) * 8) + ($urandom % 8);
        else if (k == 6) ra = 32'h80 + ($urandom % 32'h1000);
        else ra = $urandom;
        if (j == 0) wa = ra;
      end
      op = $urandom % 3;
      issue(op != 1, op != 0, wa, {$urandom, $urandom},
            (($urandom % 4) == 0) ? 8'hFF : 8'($urandom), ra);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
